// File: rtl/tqvp_hx2003_pulse_job_scheduler.sv
// Descriptor queue and sequencer that drives the pulse transmitter's bus-side
// write port: load program window, start, wait for the running bit, retire.
module tqvp_hx2003_pulse_job_scheduler #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned COUNT_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [31:0]        job_word,
  input  logic               abort,
  input  logic               irq_clear,
  output logic [5:0]         tx_address,
  output logic [31:0]        tx_data,
  output logic [1:0]         tx_write_n,
  input  logic [31:0]        tx_status,
  output logic               busy,
  output logic [COUNT_W-1:0] queue_count,
  output logic               job_done,
  output logic               job_aborted,
  output logic               interrupt
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  localparam logic [5:0]  ADDR_CTRL  = 6'h00;
  localparam logic [5:0]  ADDR_PROG  = 6'h04;
  localparam logic [31:0] CTRL_START = 32'h14;
  localparam logic [31:0] CTRL_STOP  = 32'h20;
  localparam logic [1:0]  WR_IDLE    = 2'b11;
  localparam logic [1:0]  WR_32      = 2'b10;
  localparam logic [1:0]  WR_8       = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_ARM, S_RUN, S_STOP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count_q;
  logic               flush_all, flush_tail, push, pop;
  logic [5:0]         addr_d;
  logic [31:0]        data_d;
  logic [1:0]         wn_d;
  logic               unused_status;

  assign unused_status = ^{tx_status[31:5], tx_status[3:0]};

  assign job_ready   = (count_q < COUNT_W'(QUEUE_DEPTH)) && !abort;
  assign push        = job_valid && job_ready;
  assign pop         = (state_q == S_DONE);
  assign queue_count = count_q;

  // Next state, abort flushes and the bus command for the upcoming cycle
  always_comb begin
    state_d    = state_q;
    flush_all  = 1'b0;
    flush_tail = 1'b0;
    addr_d     = 6'h00;
    data_d     = 32'h0;
    wn_d       = WR_IDLE;
    case (state_q)
      S_IDLE: begin
        if (abort) flush_all = 1'b1;
        else if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD, S_START, S_ARM: begin
        if (abort) begin
          state_d    = S_STOP;
          flush_tail = 1'b1;
        end else begin
          state_d = (state_q == S_LOAD) ? S_START :
                    (state_q == S_START) ? S_ARM : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d    = S_STOP;
          flush_tail = 1'b1;
        end else if (!tx_status[4]) begin
          state_d = S_DONE;
        end
      end
      S_STOP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_LOAD: begin
        wn_d   = WR_32;
        addr_d = ADDR_PROG;
        data_d = mem[rd_ptr];
      end
      S_START: begin
        wn_d   = WR_8;
        addr_d = ADDR_CTRL;
        data_d = CTRL_START;
      end
      S_STOP: begin
        wn_d   = WR_8;
        addr_d = ADDR_CTRL;
        data_d = CTRL_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Head entry remains queued until its job retires
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_all) begin
      wr_ptr  <= rd_ptr;
      count_q <= '0;
    end else if (flush_tail) begin
      wr_ptr  <= rd_ptr + PTR_W'(1);
      count_q <= COUNT_W'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + COUNT_W'(1);
      else if (pop && !push) count_q <= count_q - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_write_n  <= WR_IDLE;
      tx_address  <= 6'h00;
      tx_data     <= 32'h0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      job_aborted <= 1'b0;
      interrupt   <= 1'b0;
    end else begin
      tx_write_n  <= wn_d;
      tx_address  <= addr_d;
      tx_data     <= data_d;
      busy        <= (state_d != S_IDLE);
      job_done    <= (state_d == S_DONE);
      job_aborted <= (state_d == S_DONE) && (state_q == S_STOP);
      if (state_q == S_DONE) interrupt <= 1'b1;
      else if (irq_clear)    interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tqvp_hx2003_pulse_job_scheduler.sv
// Directed and random stimulus against a queue-based job model with a mock transmitter.
module tb_tqvp_hx2003_pulse_job_scheduler;

  logic        clk = 1'b0;
  logic        rst, job_valid, abort, irq_clear;
  logic [31:0] job_word, tx_status;
  logic        job_ready, busy, job_done, job_aborted, interrupt;
  logic [5:0]  tx_address;
  logic [31:0] tx_data;
  logic [1:0]  tx_write_n;
  logic [2:0]  queue_count;

  always #5 clk = ~clk;

  tqvp_hx2003_pulse_job_scheduler #(.QUEUE_DEPTH(4), .COUNT_W(3)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_word(job_word), .abort(abort), .irq_clear(irq_clear),
    .tx_address(tx_address), .tx_data(tx_data), .tx_write_n(tx_write_n),
    .tx_status(tx_status), .busy(busy), .queue_count(queue_count),
    .job_done(job_done), .job_aborted(job_aborted), .interrupt(interrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending descriptors, job phase (0 idle, 1 load, 2 start, 3 settle,
  // 4 running, 5 stop, 6 retire), abort-caused flag and sticky irq.
  logic [31:0] mq[$];
  int          ph;
  bit          m_abt, m_irq;
  // Mock transmitter: running flag and remaining cycles (0 = loops forever)
  bit          tx_run;
  int          tx_rem, next_dur;
  int          done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(output logic [1:0] wn, output logic [5:0] ad, output logic [31:0] dt);
    wn = 2'b11; ad = 6'h00; dt = 32'h0;
    if (ph == 1)      begin wn = 2'b10; ad = 6'h04; dt = mq[0]; end
    else if (ph == 2) begin wn = 2'b00; dt = 32'h14; end
    else if (ph == 5) begin wn = 2'b00; dt = 32'h20; end
  endtask

  task automatic cycle(input bit v, input logic [31:0] w, input bit ab, input bit clr);
    bit push, running;
    logic [1:0] wn; logic [5:0] ad; logic [31:0] dt;
    job_valid = v; job_word = w; abort = ab; irq_clear = clr;
    tx_status = {27'd0, tx_run, 4'd0};
    running = tx_run;
    #1;
    exp_bus(wn, ad, dt);
    push = v && (mq.size() < 4) && !ab;
    chk("job_ready", job_ready, (mq.size() < 4) && !ab);
    chk("tx_write_n", tx_write_n, wn);
    chk("tx_address", tx_address, ad);
    chk("tx_data", tx_data, dt);
    chk("busy", busy, ph != 0);
    chk("queue_count", queue_count, mq.size());
    chk("job_done", job_done, ph == 6);
    chk("job_aborted", job_aborted, (ph == 6) && m_abt);
    chk("interrupt", interrupt, m_irq);
    if (job_done) done_seen++;
    if (ph == 6) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    case (ph)
      0: if (ab) mq.delete(); else if (mq.size() > 0) ph = 1;
      1, 2, 3, 4: begin
        if (ab) begin
          ph = 5; m_abt = 1'b1;
          while (mq.size() > 1) void'(mq.pop_back());
        end else if (ph != 4 || !running) begin
          ph = (ph == 4) ? 6 : ph + 1;
        end
      end
      5: ph = 6;
      default: begin void'(mq.pop_front()); ph = 0; m_abt = 1'b0; end
    endcase
    if (push) mq.push_back(w);
    if (wn == 2'b00 && dt[4]) begin tx_run = 1'b1; tx_rem = next_dur; end
    else if (wn == 2'b00 && dt[5]) tx_run = 1'b0;
    else if (tx_run && tx_rem > 0) begin tx_rem--; if (tx_rem == 0) tx_run = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_ph(input int p, input int max);
    int k = 0;
    while (ph != p && k < max) begin idle(1); k++; end
    chk("wait_phase_bound", ph, p);
  endtask

  task automatic push_one(input logic [31:0] w, input int max);
    int k = 0;
    bit acc = 1'b0;
    while (!acc && k < max) begin
      acc = (mq.size() < 4);
      cycle(1'b1, w, 1'b0, 1'b0);
      k++;
    end
    chk("push_bound", acc, 1'b1);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_word = 32'h0; abort = 1'b0;
    irq_clear = 1'b0; tx_status = 32'h0;
    ph = 0; m_abt = 1'b0; m_irq = 1'b0; tx_run = 1'b0; tx_rem = 0; next_dur = 20;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_n", tx_write_n, 2'b11);
    chk("rst_addr", tx_address, 6'h00);
    chk("rst_data", tx_data, 32'h0);
    chk("rst_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", queue_count, 3'd0);
    chk("rst_irq", interrupt, 1'b0);
    rst = 1'b0;

    // Single job: fixed bus sequence
    done_seen = 0;
    cycle(1'b1, 32'h0003_0700, 1'b0, 1'b0);
    idle(1);
    chk("load_wn", tx_write_n, 2'b10);
    chk("load_addr", tx_address, 6'h04);
    chk("load_data", tx_data, 32'h0003_0700);
    idle(1);
    chk("start_wn", tx_write_n, 2'b00);
    chk("start_addr", tx_address, 6'h00);
    chk("start_data", tx_data, 32'h14);
    idle(30);
    chk("single_done_cnt", done_seen, 1);
    chk("single_irq", interrupt, 1'b1);
    chk("single_count", queue_count, 3'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-to-back
    next_dur = 5; done_seen = 0;
    for (int i = 0; i < 3; i++) push_one(32'h0001_0200 + 32'(i), 10);
    idle(45);
    chk("b2b_done_cnt", done_seen, 3);

    // Full queue
    next_dur = 30;
    for (int i = 0; i < 4; i++) push_one(32'h0002_0000 + 32'(i), 10);
    chk("full_ready", job_ready, 1'b0);
    chk("full_count", queue_count, 3'd4);
    push_one(32'h0002_0004, 100);
    next_dur = 3;
    wait_ph(0, 20);
    begin
      int k = 0;
      while ((mq.size() != 0 || ph != 0) && k < 400) begin idle(1); k++; end
      chk("full_drain", mq.size(), 0);
    end

    // Abort while running with 3 queued
    next_dur = 0; done_seen = 0;
    for (int i = 0; i < 3; i++) push_one(32'h00FF_0300 + 32'(i), 10);
    wait_ph(4, 20);
    idle(3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stop_wn", tx_write_n, 2'b00);
    chk("stop_data", tx_data, 32'h20);
    idle(1);
    chk("abort_done", job_done, 1'b1);
    chk("abort_flag", job_aborted, 1'b1);
    idle(10);
    chk("abort_count", queue_count, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done_cnt", done_seen, 1);

    // Abort in idle with two jobs held back
    next_dur = 4;
    for (int i = 0; i < 3; i++) push_one(32'h0001_0400 + 32'(i), 10);
    wait_ph(6, 60);
    idle(1);
    chk("held_count", queue_count, 3'd2);
    done_seen = 0;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    idle(6);
    chk("idle_abort_count", queue_count, 3'd0);
    chk("idle_abort_done", done_seen, 0);

    // Interrupt set wins over clear
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    next_dur = 3;
    push_one(32'h0000_0500, 10);
    wait_ph(6, 40);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_set_wins", interrupt, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_cleared", interrupt, 1'b0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      next_dur = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
